// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory access unit: FSM states,
// funct3 access-size codes, and byte-enable base patterns.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Instruction fetches are always full words, whatever funct3 happens to hold.
  function automatic size_e decode_size(input logic [2:0] f3, input logic fetch);
    if (fetch) return SZ_WORD;
    case (f3[1:0])
      F3_B[1:0]: return SZ_BYTE;
      F3_H[1:0]: return SZ_HALF;
      default:   return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// System-bus side of the memory access unit: valid/ack request channel
// with write data, byte enables and a read-data/error return.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_ack;
  logic                  bus_err;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables and lane replication,
// misalignment detection, and load extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic        i_fetch,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [2:0]  i_ld_f3,
  input  logic        i_ld_fetch,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  size_e       w_st_size;
  size_e       w_ld_size;
  logic [31:0] w_shifted;
  logic        w_signed;

  always_comb begin
    // NOTE: every output gets a default first so no branch can leave one
    // unassigned, which would otherwise infer a latch.
    w_st_size    = decode_size(i_f3, i_fetch);
    o_be         = BE_WORD;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (w_st_size)
      SZ_BYTE: begin
        o_be    = BE_BYTE << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be         = BE_HALF << i_off;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_off[0];
      end
      default: o_misaligned = |i_off;
    endcase
  end

  always_comb begin
    w_ld_size = decode_size(i_ld_f3, i_ld_fetch);
    w_shifted = i_rdata >> {i_ld_off, 3'b000};
    w_signed  = ~i_ld_f3[2];
    o_rdata   = i_rdata;
    case (w_ld_size)
      SZ_BYTE: o_rdata = {{24{w_signed & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_rdata = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns held mem_read/mem_write requests from the control
// FSM into one valid/ack bus transaction and a single-cycle completion pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  fetch,
  input  logic [2:0]            f3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  mem_complete,
  output logic                  misaligned,
  output logic                  access_fault,
  mem_access_unit_if.master     bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                r_state;
  state_e                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]            r_bus_be;
  logic [31:0]           r_bus_wdata;
  logic [2:0]            r_ld_f3;
  logic                  r_ld_fetch;
  logic [1:0]            r_ld_off;
  logic [31:0]           r_rdata;
  logic                  r_misaligned;
  logic                  r_fault;

  logic                  w_req;
  logic                  w_timeout;
  logic                  w_issue;
  logic                  w_set_mis;
  logic                  w_bus_end;
  logic                  w_capture;
  logic                  w_fault_set;
  logic                  w_fault_val;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_lanes;
  logic                  w_mis;
  logic [31:0]           w_ld_data;

  mem_align u_align (
    .i_f3         (f3),
    .i_fetch      (fetch),
    .i_off        (addr[1:0]),
    .i_wdata      (wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata_lanes),
    .o_misaligned (w_mis),
    .i_ld_f3      (r_ld_f3),
    .i_ld_fetch   (r_ld_fetch),
    .i_ld_off     (r_ld_off),
    .i_rdata      (bus.bus_rdata),
    .o_rdata      (w_ld_data)
  );

  assign w_req     = mem_read | mem_write;
  assign w_timeout = (TIMEOUT != 0) && (32'(r_cnt) == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // A dropped request never cuts a bus cycle short: DRAIN waits for the
  // ack (or timeout) so the bus protocol stays intact.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_set_mis    = 1'b0;
    w_bus_end    = 1'b0;
    w_capture    = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_val  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_mis) begin
            w_set_mis    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_issue      = 1'b1;
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.bus_ack) begin
          w_bus_end = 1'b1;
          if (w_req) begin
            w_state_next = DONE;
            w_capture    = ~r_bus_we;
            w_fault_set  = 1'b1;
            w_fault_val  = bus.bus_err;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_timeout) begin
          w_bus_end = 1'b1;
          if (w_req) begin
            w_state_next = DONE;
            w_fault_set  = 1'b1;
            w_fault_val  = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else if (!w_req) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.bus_ack || w_timeout) begin
          w_bus_end    = 1'b1;
          w_state_next = IDLE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_be     <= '0;
      r_bus_wdata  <= '0;
      r_ld_f3      <= '0;
      r_ld_fetch   <= 1'b0;
      r_ld_off     <= '0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same
      // pre-edge values regardless of statement order.
      if (w_issue) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_write;
        r_bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        r_bus_be    <= mem_write ? w_be : BE_WORD;
        r_bus_wdata <= w_wdata_lanes;
        r_ld_f3     <= f3;
        r_ld_fetch  <= fetch;
        r_ld_off    <= addr[1:0];
        r_cnt       <= '0;
      end else if (w_bus_end) begin
        r_bus_req <= 1'b0;
      end

      if (r_state == BUSY || r_state == DRAIN) r_cnt <= r_cnt + CNT_W'(1);

      if (w_capture) r_rdata <= w_ld_data;

      // Status flags live only for the DONE cycle; rdata is left alone.
      if (r_state == DONE) begin
        r_misaligned <= 1'b0;
        r_fault      <= 1'b0;
      end
      if (w_set_mis)   r_misaligned <= 1'b1;
      if (w_fault_set) r_fault      <= w_fault_val;
    end
  end

  assign mem_complete  = (r_state == DONE);
  assign misaligned    = r_misaligned;
  assign access_fault  = r_fault;
  assign rdata         = r_rdata;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of accesses checked through a completion
// scoreboard, plus hand sequences for abort, late ack and async reset.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        fetch = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mem_complete;
  logic        misaligned;
  logic        access_fault;

  mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .fetch        (fetch),
    .f3           (f3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .mem_complete (mem_complete),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        fetch;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          ack_dly;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        e_fault;
    int          e_lat;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic fe, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                              input int dly, input logic er, input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd, input logic emis,
                              input logic efault, input int elat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fetch = fe; v.f3 = f; v.addr = a; v.wdata = wd;
    v.bus_rdata = brd; v.ack_dly = dly; v.err = er; v.e_addr = ea; v.e_be = ebe;
    v.e_wdata = ewd; v.e_rdata = erd; v.e_mis = emis; v.e_fault = efault; v.e_lat = elat;
    return v;
  endfunction

  task automatic drop_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    fetch     = 1'b0;
  endtask

  task automatic do_access(input vec_t v, input int idx);
    int   cyc = 0;
    int   wait_n = 0;
    bit   req_seen = 1'b0;
    bit   done = 1'b0;
    vec_t e;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; fetch = v.fetch;
    f3 = v.f3; addr = v.addr; wdata = v.wdata;
    sb.push_back(v);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.bus_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          check($sformatf("v%0d bus_addr", idx), bus.bus_addr, v.e_addr);
          check($sformatf("v%0d bus_be", idx), 32'(bus.bus_be), 32'(v.e_be));
          check($sformatf("v%0d bus_we", idx), 32'(bus.bus_we), 32'(v.wr));
          if (v.wr) check($sformatf("v%0d bus_wdata", idx), bus.bus_wdata, v.e_wdata);
        end
        if (wait_n == v.ack_dly) begin
          bus.bus_ack = 1'b1; bus.bus_err = v.err; bus.bus_rdata = v.bus_rdata;
        end else begin
          bus.bus_ack = 1'b0; bus.bus_err = 1'b0;
        end
        wait_n++;
      end else begin
        bus.bus_ack = 1'b0; bus.bus_err = 1'b0;
      end
      if (mem_complete) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL v%0d scoreboard: got mem_complete, expected none pending", idx);
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d rdata", idx), rdata, e.e_rdata);
          check($sformatf("v%0d misaligned", idx), 32'(misaligned), 32'(e.e_mis));
          check($sformatf("v%0d access_fault", idx), 32'(access_fault), 32'(e.e_fault));
          check($sformatf("v%0d latency", idx), 32'(cyc), 32'(e.e_lat));
          check($sformatf("v%0d bus_req_issued", idx), 32'(req_seen), 32'(!e.e_mis));
          check($sformatf("v%0d bus_req_at_done", idx), 32'(bus.bus_req), 32'd0);
        end
        drop_req();
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL v%0d completion: got no mem_complete in %0d cycles, expected one", idx, cyc);
      sb.delete();
      drop_req();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = '0;

    //        rd wr fe f3     addr          wdata         bus_rdata     dly er e_addr        be       e_wdata       e_rdata       mis flt lat
    vecs.push_back(mk(1, 0, 0, F3_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF,  0, 0, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_BEEF, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, F3_B,  32'h0000_0103, 32'h0,         32'h8000_0000,  0, 0, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_FF80, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, F3_BU, 32'h0000_0103, 32'h0,         32'h8000_0000,  0, 0, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_0080, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, F3_H,  32'h0000_0202, 32'h1234_ABCD, 32'h0,          1, 0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, F3_W,  32'h0000_0101, 32'h0,         32'h0,          0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, F3_B,  32'h0000_0002, 32'h0,         32'h0,          0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, F3_W,  32'h0000_0300, 32'hCAFE_F00D, 32'h0,          0, 1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0000_0080, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, F3_H,  32'h0000_0106, 32'h0,         32'h8001_7FFF,  0, 0, 32'h0000_0104, 4'b1111, 32'h0,         32'hFFFF_8001, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, F3_HU, 32'h0000_0106, 32'h0,         32'h8001_7FFF,  2, 0, 32'h0000_0104, 4'b1111, 32'h0,         32'h0000_8001, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, F3_B,  32'h0000_0401, 32'h0000_00A5, 32'h0,          0, 0, 32'h0000_0400, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, F3_B,  32'h0000_0001, 32'h0,         32'h0000_7F00,  0, 0, 32'h0000_0000, 4'b1111, 32'h0,         32'h0000_007F, 0, 0, 2));
    vecs.push_back(mk(1, 0, 1, F3_B,  32'h0000_0010, 32'h0,         32'h0000_00F3,  0, 0, 32'h0000_0010, 4'b1111, 32'h0,         32'h0000_00F3, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, F3_W,  32'h0000_0200, 32'h0,         32'h0,         99, 0, 32'h0000_0200, 4'b1111, 32'h0,         32'h0000_00F3, 0, 1, TO + 1));
    vecs.push_back(mk(1, 1, 0, F3_W,  32'h0000_0500, 32'h1122_3344, 32'h0,          0, 0, 32'h0000_0500, 4'b1111, 32'h1122_3344, 32'h0000_00F3, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, F3_H,  32'h0000_0203, 32'h0,         32'h0,          0, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_00F3, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, F3_H,  32'h0000_0102, 32'h0,         32'h1234_5678,  0, 0, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_1234, 0, 0, 2));

    // Reset state
    repeat (2) @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_complete", 32'(mem_complete), 32'h0);
    check("reset misaligned", 32'(misaligned), 32'h0);
    check("reset access_fault", 32'(access_fault), 32'h0);
    check("reset bus_req", 32'(bus.bus_req), 32'h0);
    check("reset bus_be", 32'(bus.bus_be), 32'h0);
    check("reset bus_addr", bus.bus_addr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) do_access(vecs[i], i);

    // Abort: request drops during BUSY, bus cycle still runs to its ack
    @(negedge clk);
    mem_read = 1'b1; f3 = F3_W; addr = 32'h0000_0700; fetch = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("abort bus_req issued", 32'(bus.bus_req), 32'h1);
    mem_read = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("abort bus_req held c%0d", k), 32'(bus.bus_req), 32'h1);
      check($sformatf("abort no complete c%0d", k), 32'(mem_complete), 32'h0);
      if (k == 4) begin
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h9999_9999;
      end
    end
    @(negedge clk);
    bus.bus_ack = 1'b0;
    check("abort bus_req released", 32'(bus.bus_req), 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort no complete after ack %0d", k), 32'(mem_complete), 32'h0);
      @(negedge clk);
    end
    check("abort rdata unchanged", rdata, 32'h0000_1234);
    do_access(mk(1, 0, 0, F3_W, 32'h0000_0704, 32'h0, 32'h0BAD_F00D, 0, 0, 32'h0000_0704, 4'b1111,
                 32'h0, 32'h0BAD_F00D, 0, 0, 2), 100);

    // Late ack after a timeout is ignored
    do_access(mk(1, 0, 0, F3_W, 32'h0000_0600, 32'h0, 32'h0, 99, 0, 32'h0000_0600, 4'b1111,
                 32'h0, 32'h0BAD_F00D, 0, 1, TO + 1), 101);
    @(negedge clk);
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5555_5555;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("late ack no complete %0d", k), 32'(mem_complete), 32'h0);
      check($sformatf("late ack no bus_req %0d", k), 32'(bus.bus_req), 32'h0);
      @(negedge clk);
    end
    check("late ack rdata unchanged", rdata, 32'h0BAD_F00D);

    // Asynchronous reset in the middle of a bus cycle
    mem_read = 1'b1; f3 = F3_W; addr = 32'h0000_0800;
    @(negedge clk);
    check("async rst bus_req before", 32'(bus.bus_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst bus_req", 32'(bus.bus_req), 32'h0);
    check("async rst rdata", rdata, 32'h0);
    check("async rst mem_complete", 32'(mem_complete), 32'h0);
    drop_req();
    @(negedge clk);
    rst_n = 1'b1;
    do_access(mk(1, 0, 0, F3_BU, 32'h0000_0803, 32'h0, 32'hAB00_0000, 0, 0, 32'h0000_0800, 4'b1111,
                 32'h0, 32'h0000_00AB, 0, 0, 2), 102);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
